tof_delay_scheduler: RTL

Round-robin scheduler that shares one `tof_delay_line` instance between `NREQ` time-of-flight requesters. It accepts per-requester pulse requests (valid/ready with a delay value) and issues at most one pulse per enabled cycle to the delay line. It tracks outstanding in-flight pulses against the line's slot capacity so that no pulse is ever dropped. An enable/drain state machine lets firmware stop the line cleanly, waiting until every in-flight pulse has returned.

---
 rtl/tof_delay_scheduler.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/tof_delay_scheduler.sv
// Round-robin arbiter sharing one delay line between NREQ requesters, with
// slot-credit tracking and an enable/drain state machine.
module tof_delay_scheduler #(
    parameter  int unsigned NREQ      = 4,
    parameter  int unsigned MAX_DELAY = 256,
    parameter  int unsigned SLOTS     = 8,
    localparam int unsigned WDL       = $clog2(MAX_DELAY),
    localparam int unsigned CW        = $clog2(SLOTS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  en_i,
    input  logic [NREQ-1:0]       req_valid_i,
    input  logic [NREQ*WDL-1:0]   req_delay_i,
    output logic [NREQ-1:0]       req_ready_o,
    output logic                  dl_pulse_o,
    output logic [WDL-1:0]        dl_delay_o,
    input  logic                  dl_return_i,
    output logic [CW-1:0]         outstanding_o,
    output logic [1:0]            state_o,
    output logic                  drain_done_o,
    output logic                  underflow_o
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic            dl_pulse_q, dl_pulse_d;
    logic [WDL-1:0]  dl_delay_q, dl_delay_d;
    logic            drain_done_q, drain_done_d;
    logic            underflow_q, underflow_d;

    logic            grant_ok_c;
    logic            found_c;
    logic            issue_c;
    logic [PW-1:0]   grant_idx_c;
    logic [NREQ-1:0] ready_c;
    int unsigned     idx_c;

    // Grant allowed only while running with a free slot; reset also blocks it.
    assign grant_ok_c = rst_n && clk_en && (state_q == ST_RUN)
                        && (outstanding_q < CW'(SLOTS));

    // Rotating priority search starting at the rr pointer.
    always_comb begin
        ready_c     = '0;
        grant_idx_c = '0;
        found_c     = 1'b0;
        idx_c       = 0;
        if (grant_ok_c) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                idx_c = (32'(rr_q) + k) % NREQ;
                if (!found_c && req_valid_i[idx_c]) begin
                    found_c            = 1'b1;
                    ready_c[idx_c]     = 1'b1;
                    grant_idx_c        = PW'(idx_c);
                end
            end
        end
    end

    assign req_ready_o = ready_c;
    assign issue_c     = |(req_valid_i & ready_c);

    // Issue path, credit counter and FSM next-state.
    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        outstanding_d = outstanding_q;
        dl_pulse_d    = 1'b0;
        dl_delay_d    = dl_delay_q;
        drain_done_d  = 1'b0;
        underflow_d   = underflow_q;

        if (issue_c) begin
            dl_pulse_d = 1'b1;
            dl_delay_d = req_delay_i[32'(grant_idx_c)*WDL +: WDL];
            rr_d       = (grant_idx_c == PW'(NREQ - 1)) ? '0 : grant_idx_c + PW'(1);
        end

        if (issue_c && !dl_return_i) begin
            outstanding_d = outstanding_q + CW'(1);
        end else if (!issue_c && dl_return_i) begin
            if (outstanding_q == '0) begin
                underflow_d = 1'b1;
            end else begin
                outstanding_d = outstanding_q - CW'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (en_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!en_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (en_i) begin
                    state_d = ST_RUN;
                end else if (outstanding_q == '0 && !issue_c && !dl_return_i) begin
                    state_d      = ST_IDLE;
                    drain_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rr_q          <= '0;
            outstanding_q <= '0;
            dl_pulse_q    <= 1'b0;
            dl_delay_q    <= '0;
            drain_done_q  <= 1'b0;
            underflow_q   <= 1'b0;
        end else if (clk_en) begin
            state_q       <= state_d;
            rr_q          <= rr_d;
            outstanding_q <= outstanding_d;
            dl_pulse_q    <= dl_pulse_d;
            dl_delay_q    <= dl_delay_d;
            drain_done_q  <= drain_done_d;
            underflow_q   <= underflow_d;
        end
    end

    assign dl_pulse_o    = dl_pulse_q;
    assign dl_delay_o    = dl_delay_q;
    assign outstanding_o = outstanding_q;
    assign state_o       = 2'(state_q);
    assign drain_done_o  = drain_done_q;
    assign underflow_o   = underflow_q;

endmodule
